// File: rtl/controller_sequencer.sv
// Six-state ring-counter controller for a simple accumulator machine.
// Control lines are decoded from the registered T-state for falling-edge consumers.
module controller_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    output logic       cp,
    output logic       ep,
    output logic       lm,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb,
    output logic       lo,
    output logic       hlt,
    output logic [5:0] tstate
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [5:0] {
        T1   = 6'b000001,
        T2   = 6'b000010,
        T3   = 6'b000100,
        T4   = 6'b001000,
        T5   = 6'b010000,
        T6   = 6'b100000,
        HALT = 6'b000000
    } state_t;

    state_t     state;
    logic [3:0] op_q;

    // Ring advance; opcode captured leaving T4, HLT parks the ring.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= T1;
            op_q  <= 4'b0000;
        end else begin
            case (state)
                T1: state <= T2;
                T2: state <= T3;
                T3: state <= T4;
                T4: begin
                    op_q  <= opcode;
                    state <= (opcode == OP_HLT) ? HALT : T5;
                end
                T5:      state <= T6;
                T6:      state <= T1;
                HALT:    state <= HALT;
                default: state <= T1;
            endcase
        end
    end

    // Control decode: T4 uses the live opcode, T5/T6 the captured copy.
    always_comb begin
        cp  = 1'b0;
        ep  = 1'b0;
        lm  = 1'b0;
        ce  = 1'b0;
        li  = 1'b0;
        ei  = 1'b0;
        la  = 1'b0;
        ea  = 1'b0;
        su  = 1'b0;
        eu  = 1'b0;
        lb  = 1'b0;
        lo  = 1'b0;
        hlt = 1'b0;
        case (state)
            T1: begin
                ep = 1'b1;
                lm = 1'b1;
            end
            T2: cp = 1'b1;
            T3: begin
                ce = 1'b1;
                li = 1'b1;
            end
            T4: begin
                if (opcode == OP_LDA || opcode == OP_ADD ||
                    opcode == OP_SUB) begin
                    ei = 1'b1;
                    lm = 1'b1;
                end else if (opcode == OP_OUT) begin
                    ea = 1'b1;
                    lo = 1'b1;
                end
            end
            T5: begin
                if (op_q == OP_LDA) begin
                    ce = 1'b1;
                    la = 1'b1;
                end else if (op_q == OP_ADD || op_q == OP_SUB) begin
                    ce = 1'b1;
                    lb = 1'b1;
                end
            end
            T6: begin
                if (op_q == OP_ADD || op_q == OP_SUB) begin
                    la = 1'b1;
                    eu = 1'b1;
                    su = (op_q == OP_SUB);
                end
            end
            HALT:    hlt = 1'b1;
            default: ;
        endcase
    end

    assign tstate = state;

endmodule

// File: tb/tb_controller_sequencer.sv
// Randomized and directed bench for controller_sequencer against a
// cycle-step reference model of the instruction cycle.
module tb_controller_sequencer;

    logic       clk;
    logic       reset;
    logic [3:0] opcode;
    logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;
    logic [5:0] tstate;

    int n_tests;
    int n_fail;

    // reference model state
    int         m_step;
    bit         m_halt;
    logic [3:0] m_lat;

    localparam logic [12:0] B_CP = 13'h1000;
    localparam logic [12:0] B_EP = 13'h0800;
    localparam logic [12:0] B_LM = 13'h0400;
    localparam logic [12:0] B_CE = 13'h0200;
    localparam logic [12:0] B_LI = 13'h0100;
    localparam logic [12:0] B_EI = 13'h0080;
    localparam logic [12:0] B_LA = 13'h0040;
    localparam logic [12:0] B_EA = 13'h0020;
    localparam logic [12:0] B_SU = 13'h0010;
    localparam logic [12:0] B_EU = 13'h0008;
    localparam logic [12:0] B_LB = 13'h0004;
    localparam logic [12:0] B_LO = 13'h0002;
    localparam logic [12:0] B_HL = 13'h0001;

    controller_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .opcode (opcode),
        .cp     (cp),
        .ep     (ep),
        .lm     (lm),
        .ce     (ce),
        .li     (li),
        .ei     (ei),
        .la     (la),
        .ea     (ea),
        .su     (su),
        .eu     (eu),
        .lb     (lb),
        .lo     (lo),
        .hlt    (hlt),
        .tstate (tstate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Which control lines the instruction cycle calls for at this point.
    function automatic logic [12:0] expect_ctrl(input int step, input bit halted,
                                                input logic [3:0] live,
                                                input logic [3:0] lat);
        logic [12:0] v;
        v = '0;
        if (halted) return B_HL;
        case (step)
            0: v = B_EP | B_LM;
            1: v = B_CP;
            2: v = B_CE | B_LI;
            3: begin
                if (live <= 4'd2) v = B_EI | B_LM;
                else if (live == 4'hE) v = B_EA | B_LO;
            end
            4: begin
                if (lat == 4'd0) v = B_CE | B_LA;
                else if (lat == 4'd1 || lat == 4'd2) v = B_CE | B_LB;
            end
            5: begin
                if (lat == 4'd1) v = B_LA | B_EU;
                else if (lat == 4'd2) v = B_LA | B_EU | B_SU;
            end
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic check_all();
        logic [12:0] got;
        logic [5:0]  ts_exp;
        bit          ok;
        got = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt};
        ts_exp = m_halt ? 6'b0 : 6'(1 << m_step);
        chk("ctrl", 32'(got), 32'(expect_ctrl(m_step, m_halt, opcode, m_lat)));
        chk("tstate", 32'(tstate), 32'(ts_exp));
        chk("bus", 32'($countones({ep, ce, ei, ea, eu}) <= 1), 32'd1);
        ok = $onehot(tstate) || (tstate == 6'b0 && hlt);
        chk("onehot", 32'(ok), 32'd1);
    endtask

    // One clock: drive, check at falling edge, advance model at rising edge.
    task automatic cyc(input logic r, input logic [3:0] op);
        reset  = r;
        opcode = op;
        @(negedge clk);
        check_all();
        @(posedge clk);
        if (!r) begin
            m_step = 0;
            m_halt = 0;
            m_lat  = 4'd0;
        end else if (!m_halt) begin
            if (m_step == 3) begin
                m_lat = op;
                if (op == 4'hF) m_halt = 1;
                else m_step = 4;
            end else begin
                m_step = (m_step + 1) % 6;
            end
        end
        #1;
    endtask

    task automatic instr(input logic [3:0] op, input logic [3:0] late);
        for (int i = 0; i < 4; i++) cyc(1'b1, op);
        cyc(1'b1, late);
        cyc(1'b1, late);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        opcode  = 4'd0;
        @(posedge clk);
        #1;
        m_step = 0;
        m_halt = 0;
        m_lat  = 4'd0;

        // reset held, then fetch and LDA
        cyc(1'b0, 4'd0);
        cyc(1'b0, 4'd0);
        chk("rst_ts", 32'(tstate), 32'h01);
        for (int i = 0; i < 6; i++) cyc(1'b1, 4'd0);
        chk("lda_wrap", 32'(tstate), 32'h01);

        // ADD then SUB, opcode disturbed during T5/T6
        instr(4'd1, 4'd5);
        instr(4'd2, 4'hF);
        chk("sub_wrap", 32'(tstate), 32'h01);

        // OUT then HLT, hold, reset out of HALT
        instr(4'hE, 4'd3);
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'hF);
        chk("halt_ts", 32'(tstate), 32'h00);
        chk("halt_h", 32'(hlt), 32'd1);
        for (int i = 0; i < 20; i++) cyc(1'b1, 4'($urandom_range(0, 15)));
        cyc(1'b0, 4'd1);
        chk("unhalt_ts", 32'(tstate), 32'h01);
        chk("unhalt_eplm", 32'({ep, lm, hlt}), 32'b110);

        // reset during T5 of ADD
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'd1);
        cyc(1'b0, 4'd1);
        chk("mid_ts", 32'(tstate), 32'h01);
        chk("mid_lb", 32'(lb), 32'd0);
        cyc(1'b1, 4'd1);
        chk("rel_t2", 32'(tstate), 32'h02);

        // random opcodes with occasional reset
        for (int i = 0; i < 1000; i++)
            cyc(1'($urandom_range(0, 49) != 0), 4'($urandom_range(0, 15)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
